// File: rtl/apb_pwm_multi_if.sv
// rtl/apb_pwm_multi_if.sv - APB3 bus bundle for the multi-channel PWM timer
interface apb_pwm_multi_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                  PSEL_i;
  logic                  PENABLE_i;
  logic                  PWRITE_i;
  logic [ADDR_WIDTH-1:0] PADDR_i;
  logic [DATA_WIDTH-1:0] PWDATA_i;
  logic [DATA_WIDTH-1:0] PRDATA_o;
  logic                  PREADY_o;
  logic                  PSLVERR_o;

  modport master (
    output PSEL_i, PENABLE_i, PWRITE_i, PADDR_i, PWDATA_i,
    input  PRDATA_o, PREADY_o, PSLVERR_o
  );

  modport slave (
    input  PSEL_i, PENABLE_i, PWRITE_i, PADDR_i, PWDATA_i,
    output PRDATA_o, PREADY_o, PSLVERR_o
  );
endinterface

// File: rtl/apb_pwm_multi.sv
// rtl/apb_pwm_multi.sv - N-channel APB3 PWM timer, edge/center aligned, double-buffered
// Channel c registers at c*0x10; IRQ_STAT at 0xF0, IRQ_EN at 0xF4.
module apb_pwm_multi #(
  parameter int NUM_CH     = 4,
  parameter int CNT_WIDTH  = 16,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic              PCLK_i,
  input  logic              PRST_i,
  apb_pwm_multi_if.slave    apb,
  output logic [NUM_CH-1:0] pwm_o,
  output logic [NUM_CH-1:0] pwm_oe_o,
  output logic              irq_o
);
  typedef logic [CNT_WIDTH-1:0] cnt_t;

  logic [ADDR_WIDTH-1:0] paddr;
  logic [3:0]            ch_idx;
  logic [1:0]            reg_idx;
  logic                  access, err, wr, rd, is_global, glob_ok, ch_ok, gwr;
  logic [DATA_WIDTH-1:0] prdata;

  assign paddr     = apb.PADDR_i;
  assign ch_idx    = paddr[7:4];
  assign reg_idx   = paddr[3:2];
  assign is_global = (ch_idx == 4'hF);
  assign glob_ok   = is_global && !paddr[3];
  assign ch_ok     = !is_global && (ch_idx < 4'(NUM_CH));
  assign access    = apb.PSEL_i && apb.PENABLE_i;
  assign err       = access && ((paddr[1:0] != 2'b00) || !(ch_ok || glob_ok));
  assign wr        = access && apb.PWRITE_i && !err;
  assign rd        = access && !apb.PWRITE_i && !err;
  assign gwr       = wr && is_global;

  assign apb.PREADY_o  = 1'b1;
  assign apb.PSLVERR_o = err;

  logic [2:0]        ctrl_v [NUM_CH];
  cnt_t              div_v  [NUM_CH];
  cnt_t              per_v  [NUM_CH];
  cnt_t              duty_v [NUM_CH];
  logic [NUM_CH-1:0] bnd;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic en, mode, inv, down, pwm_q;
    cnt_t div_r, per_sh, duty_sh, per_a, duty_a, presc, cnt, per_m1;
    logic wr_ch, en_nxt, tick, pz, load, raw;

    assign wr_ch  = wr && (ch_idx == 4'(c));
    assign en_nxt = (wr_ch && reg_idx == 2'd0) ? apb.PWDATA_i[0] : en;
    assign tick   = en && (presc >= div_r);
    assign pz     = (per_a == '0);
    assign per_m1 = per_a - cnt_t'(1);
    // Edge boundary is the wrap to 0; center boundary is the last 0 of the down ramp.
    assign bnd[c] = tick && (pz || (mode ? (down && cnt == '0) : (cnt == per_m1)));
    assign load   = !en || !en_nxt || bnd[c];
    assign raw    = !pz && (cnt < duty_a);

    always_ff @(posedge PCLK_i or posedge PRST_i) begin
      if (PRST_i) begin
        en <= 1'b0; mode <= 1'b0; inv <= 1'b0; down <= 1'b0; pwm_q <= 1'b0;
        div_r <= '0; per_sh <= '0; duty_sh <= '0; per_a <= '0; duty_a <= '0;
        presc <= '0; cnt <= '0;
      end else begin
        if (wr_ch) begin
          case (reg_idx)
            2'd0:    {inv, mode, en} <= apb.PWDATA_i[2:0];
            2'd1:    div_r   <= apb.PWDATA_i[CNT_WIDTH-1:0];
            2'd2:    per_sh  <= apb.PWDATA_i[CNT_WIDTH-1:0];
            default: duty_sh <= apb.PWDATA_i[CNT_WIDTH-1:0];
          endcase
        end
        if (load) begin
          per_a  <= per_sh;
          duty_a <= duty_sh;
        end
        if (!en_nxt) begin
          presc <= '0;
          cnt   <= '0;
          down  <= 1'b0;
        end else if (tick) begin
          presc <= '0;
          if (pz) begin
            cnt <= '0;
          end else if (!mode) begin
            cnt <= (cnt == per_m1) ? '0 : cnt + cnt_t'(1);
          end else if (!down) begin
            // The top value is held for a second tick as the ramp turns.
            if (cnt == per_m1) down <= 1'b1;
            else               cnt  <= cnt + cnt_t'(1);
          end else begin
            if (cnt == '0) down <= 1'b0;
            else           cnt  <= cnt - cnt_t'(1);
          end
        end else if (en) begin
          presc <= presc + cnt_t'(1);
        end
        pwm_q <= en && (raw ^ inv);
      end
    end

    assign pwm_o[c]    = pwm_q;
    assign pwm_oe_o[c] = en;
    assign ctrl_v[c]   = {inv, mode, en};
    assign div_v[c]    = div_r;
    assign per_v[c]    = per_sh;
    assign duty_v[c]   = duty_sh;
  end

  logic [NUM_CH-1:0] stat, irq_en, stat_nxt, ien_nxt, clr;

  assign clr      = (gwr && !paddr[2]) ? apb.PWDATA_i[NUM_CH-1:0] : '0;
  assign stat_nxt = (stat & ~clr) | bnd;
  assign ien_nxt  = (gwr && paddr[2]) ? apb.PWDATA_i[NUM_CH-1:0] : irq_en;

  always_ff @(posedge PCLK_i or posedge PRST_i) begin
    if (PRST_i) begin
      stat   <= '0;
      irq_en <= '0;
      irq_o  <= 1'b0;
    end else begin
      stat   <= stat_nxt;
      irq_en <= ien_nxt;
      irq_o  <= |(stat_nxt & ien_nxt);
    end
  end

  always_comb begin
    prdata = '0;
    if (rd) begin
      if (is_global) begin
        prdata = paddr[2] ? DATA_WIDTH'(irq_en) : DATA_WIDTH'(stat);
      end else begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (ch_idx == 4'(c)) begin
            case (reg_idx)
              2'd0:    prdata = DATA_WIDTH'(ctrl_v[c]);
              2'd1:    prdata = DATA_WIDTH'(div_v[c]);
              2'd2:    prdata = DATA_WIDTH'(per_v[c]);
              default: prdata = DATA_WIDTH'(duty_v[c]);
            endcase
          end
        end
      end
    end
  end

  assign apb.PRDATA_o = prdata;

  logic unused;
  assign unused = ^{apb.PWDATA_i, paddr};
endmodule

// File: tb/tb_apb_pwm_multi.sv
// tb/tb_apb_pwm_multi.sv - scoreboard bench for apb_pwm_multi
module tb_apb_pwm_multi;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] pwm, oe;
  logic       irq;
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         n0, c1;
  logic       smp = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  apb_pwm_multi_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

  apb_pwm_multi #(.NUM_CH(4), .CNT_WIDTH(16), .DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
    .PCLK_i(clk), .PRST_i(rst), .apb(bus), .pwm_o(pwm), .pwm_oe_o(oe), .irq_o(irq)
  );

  typedef struct { string name; logic [31:0] mask; logic [31:0] data; logic err; } rd_exp_t;
  typedef struct { string name; logic [8:0] mask; logic [8:0] val; } out_exp_t;
  rd_exp_t  rd_q[$];
  out_exp_t out_q[$];
  rd_exp_t  re;
  out_exp_t oxe;

  // Monitor: reads are checked in their access phase, outputs whenever smp is raised.
  always @(negedge clk) begin
    if (bus.PSEL_i && bus.PENABLE_i && !bus.PWRITE_i) begin
      checks++;
      if (rd_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_read: addr=%h", bus.PADDR_i);
      end else begin
        re = rd_q.pop_front();
        if (((bus.PRDATA_o & re.mask) !== (re.data & re.mask)) ||
            ({bus.PREADY_o, bus.PSLVERR_o} !== {1'b1, re.err})) begin
          failures++;
          $display("FAIL %s: got data=%h ready=%b err=%b, want data=%h ready=1 err=%b (mask %h)",
                   re.name, bus.PRDATA_o, bus.PREADY_o, bus.PSLVERR_o, re.data, re.err, re.mask);
        end
      end
    end
    if (smp) begin
      checks++;
      if (out_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_sample");
      end else begin
        oxe = out_q.pop_front();
        if (({irq, oe, pwm} & oxe.mask) !== (oxe.val & oxe.mask)) begin
          failures++;
          $display("FAIL %s: got {irq,oe,pwm}=%b, want %b (mask %b)",
                   oxe.name, {irq, oe, pwm}, oxe.val, oxe.mask);
        end
      end
    end
  end

  task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
    bus.PSEL_i = 1'b1; bus.PWRITE_i = 1'b1; bus.PENABLE_i = 1'b0;
    bus.PADDR_i = a; bus.PWDATA_i = d;
    @(posedge clk); #1 bus.PENABLE_i = 1'b1;
    @(posedge clk); #1 bus.PSEL_i = 1'b0; bus.PENABLE_i = 1'b0; bus.PWRITE_i = 1'b0;
  endtask

  task automatic apb_read(input string n, input logic [7:0] a, input logic [31:0] m,
                          input logic [31:0] d, input logic e);
    rd_q.push_back('{name: n, mask: m, data: d, err: e});
    bus.PSEL_i = 1'b1; bus.PWRITE_i = 1'b0; bus.PENABLE_i = 1'b0; bus.PADDR_i = a;
    @(posedge clk); #1 bus.PENABLE_i = 1'b1;
    @(posedge clk); #1 bus.PSEL_i = 1'b0; bus.PENABLE_i = 1'b0;
  endtask

  task automatic expect_out(input string n, input logic [8:0] m, input logic [8:0] v);
    out_q.push_back('{name: n, mask: m, val: v});
    smp = 1'b1;
    @(posedge clk); #1 smp = 1'b0;
  endtask

  task automatic wait_cyc(input int c);
    int guard = 0;
    while (cyc < c && guard < 1000) begin
      @(posedge clk); #1;
      guard++;
    end
    checks++;
    if (cyc != c) begin
      failures++;
      $display("FAIL wait_cyc: got cyc=%0d, want %0d", cyc, c);
    end
  endtask

  function automatic logic exp_edge(input int k);
    if (k == 0) return 1'b0;
    if (k <= 20) return ((k - 1) % 10) < 3;
    return ((k - 21) % 10) < 6;
  endfunction

  function automatic logic exp_ctr(input int k);
    int s;
    if (k == 0) return 1'b0;
    s = ((k - 1) / 2) % 16;
    return (s < 2) || (s >= 14);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    bus.PSEL_i = 1'b0; bus.PENABLE_i = 1'b0; bus.PWRITE_i = 1'b0;
    bus.PADDR_i = '0; bus.PWDATA_i = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    expect_out("reset_outputs", 9'h1FF, 9'h000);
    apb_read("reset_ctrl0", 8'h00, 32'hFFFF_FFFF, 32'h0, 1'b0);
    apb_read("reset_irq_stat", 8'hF0, 32'hFFFF_FFFF, 32'h0, 1'b0);

    // Ch0 edge mode 10/3, DUTY rewritten to 6 two cycles into the second period.
    apb_write(8'h08, 32'd10);
    apb_write(8'h0C, 32'd3);
    apb_write(8'h00, 32'h1);
    n0 = cyc;
    fork
      for (int k = 0; k <= 40; k++)
        expect_out($sformatf("ch0_edge_k%0d", k), 9'h011, {4'b0, 4'b0001, 3'b000, exp_edge(k)});
      begin
        wait_cyc(n0 + 10);
        apb_write(8'h0C, 32'd6);
      end
    join

    apb_write(8'hF4, 32'h1);
    expect_out("irq_after_en", 9'h100, 9'h100);
    wait_cyc(n0 + 48);
    apb_write(8'hF0, 32'h1);
    expect_out("irq_w1c_on_boundary", 9'h100, 9'h100);
    apb_read("stat_w1c_on_boundary", 8'hF0, 32'h1, 32'h1, 1'b0);
    apb_write(8'hF0, 32'h1);
    expect_out("irq_w1c_off_boundary", 9'h100, 9'h000);
    apb_read("stat_w1c_off_boundary", 8'hF0, 32'h1, 32'h0, 1'b0);

    // Ch1 center mode: DIV=1, PERIOD=8, DUTY=2.
    apb_write(8'h14, 32'd1);
    apb_write(8'h18, 32'd8);
    apb_write(8'h1C, 32'd2);
    apb_write(8'h10, 32'h3);
    c1 = cyc;
    for (int k = 0; k <= 40; k++)
      expect_out($sformatf("ch1_center_k%0d", k), 9'h002, {7'b0, exp_ctr(k), 1'b0});
    apb_read("ch1_stat_set", 8'hF0, 32'h2, 32'h2, 1'b0);
    apb_write(8'hF0, 32'h2);
    apb_read("ch1_stat_cleared", 8'hF0, 32'h2, 32'h0, 1'b0);
    wait_cyc(c1 + 58);
    apb_read("ch1_stat_not_early", 8'hF0, 32'h2, 32'h0, 1'b0);
    wait_cyc(c1 + 65);
    apb_read("ch1_stat_once", 8'hF0, 32'h2, 32'h2, 1'b0);

    apb_read("ch0_duty_shadow", 8'h0C, 32'hFFFF_FFFF, 32'd6, 1'b0);
    apb_read("ch1_period_shadow", 8'h18, 32'hFFFF_FFFF, 32'd8, 1'b0);
    apb_read("ch1_ctrl", 8'h10, 32'hFFFF_FFFF, 32'h3, 1'b0);

    apb_read("err_ch4", 8'h40, 32'hFFFF_FFFF, 32'h0, 1'b1);
    apb_read("err_misaligned", 8'h02, 32'hFFFF_FFFF, 32'h0, 1'b1);
    apb_read("err_global", 8'hF8, 32'hFFFF_FFFF, 32'h0, 1'b1);
    apb_write(8'h06, 32'hFF);
    apb_write(8'h44, 32'h55);
    apb_read("div0_untouched", 8'h04, 32'hFFFF_FFFF, 32'h0, 1'b0);
    apb_write(8'h34, 32'hABCD_1234);
    apb_read("div3_truncated", 8'h34, 32'hFFFF_FFFF, 32'h1234, 1'b0);

    // Disable with INV set: OE drops at once, PWM forced low one cycle later.
    apb_write(8'h00, 32'h4);
    expect_out("oe0_off", 9'h010, 9'h000);
    expect_out("pwm0_off_inv", 9'h001, 9'h000);

    apb_write(8'h00, 32'h5);
    repeat (7) begin @(posedge clk); #1; end
    expect_out("pwm0_inverted", 9'h001, 9'h001);

    rst = 1'b1;
    expect_out("async_reset_outputs", 9'h1FF, 9'h000);
    rst = 1'b0;
    expect_out("post_reset_outputs", 9'h1FF, 9'h000);
    apb_read("post_reset_ctrl0", 8'h00, 32'hFFFF_FFFF, 32'h0, 1'b0);
    apb_read("post_reset_period0", 8'h08, 32'hFFFF_FFFF, 32'h0, 1'b0);
    apb_read("post_reset_duty0", 8'h0C, 32'hFFFF_FFFF, 32'h0, 1'b0);
    apb_read("post_reset_div3", 8'h34, 32'hFFFF_FFFF, 32'h0, 1'b0);
    apb_read("post_reset_ctrl1", 8'h10, 32'hFFFF_FFFF, 32'h0, 1'b0);
    apb_read("post_reset_irq_stat", 8'hF0, 32'hFFFF_FFFF, 32'h0, 1'b0);
    apb_read("post_reset_irq_en", 8'hF4, 32'hFFFF_FFFF, 32'h0, 1'b0);

    checks++;
    if (rd_q.size() != 0 || out_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got rd=%0d out=%0d pending, want 0", rd_q.size(), out_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
